// File: rtl/apb_timer_nch.sv
// apb_timer_nch: N-channel APB down-counting timer with a shared prescaler.
//
// Each channel has a LOAD value, a CTRL register (EN, MODE, MASK) and a raw expiry flag.
// Running channels count down once per prescaler tick; reaching zero and ticking again
// is an expiry that sets the raw flag and reloads the counter (from LOAD in user mode,
// all-ones in free-run mode). intr is the raw flag gated by MASK.
//
// Optional feature: define TIMER_ETB_EN to let the ETB pulse inputs set/clear CTRL.EN
// and to drive tim_etb_trig with a one-cycle registered expiry pulse. Without it the
// ETB inputs are ignored and tim_etb_trig is tied low.
//
// Ports:
//   pclk, preset          clock, synchronous active-high reset
//   psel, penable, pwrite APB control (zero wait states)
//   paddr[7:0]            APB byte address
//   pwdata[31:0]          APB write data
//   prdata[31:0]          APB read data, registered in the setup phase
//   intr[NCH-1:0]         masked per-channel level interrupts
//   etb_trig_en_on        per-channel ETB enable pulse
//   etb_trig_en_off       per-channel ETB disable pulse
//   tim_etb_trig          per-channel one-cycle expiry pulse
module apb_timer_nch #(
  parameter int unsigned NCH   = 2,
  parameter int unsigned CNT_W = 32,
  parameter int unsigned PSC_W = 8
) (
  input  logic             pclk,
  input  logic             preset,
  input  logic             psel,
  input  logic             penable,
  input  logic             pwrite,
  input  logic [7:0]       paddr,
  input  logic [31:0]      pwdata,
  output logic [31:0]      prdata,
  output logic [NCH-1:0]   intr,
  input  logic [NCH-1:0]   etb_trig_en_on,
  input  logic [NCH-1:0]   etb_trig_en_off,
  output logic [NCH-1:0]   tim_etb_trig
);

  typedef enum logic {StIdle, StRun} state_e;

  state_e           state_q [NCH];
  state_e           state_d [NCH];
  logic [CNT_W-1:0] load_q  [NCH];
  logic [CNT_W-1:0] cnt_q   [NCH];
  logic [CNT_W-1:0] cnt_d   [NCH];

  logic [NCH-1:0]   en_q, en_d;
  logic [NCH-1:0]   mode_q, mask_q;
  logic [NCH-1:0]   raw_q, raw_d;
  logic [NCH-1:0]   expire;
  logic [NCH-1:0]   ld_we, ctrl_we, eoi_clr;
  logic [PSC_W-1:0] psc_q, pcnt_q, pcnt_d;
  logic [31:0]      prdata_q, rdata;
  logic             tick;

  // APB decode
  logic       wr_en, rd_en, addr_ok, is_ch, is_glb;
  logic [2:0] ch_sel;
  logic [1:0] reg_sel;

  assign wr_en   = psel & penable & pwrite;
  assign rd_en   = psel & ~penable & ~pwrite;
  assign addr_ok = (paddr[1:0] == 2'b00);
  assign ch_sel  = paddr[6:4];
  assign reg_sel = paddr[3:2];
  assign is_ch   = ~paddr[7] & addr_ok & (32'(ch_sel) < NCH);
  assign is_glb  = (paddr[7:4] == 4'h8) & addr_ok;

  logic unused_pwdata;
  assign unused_pwdata = ^pwdata;

  always_comb begin
    ld_we   = '0;
    ctrl_we = '0;
    eoi_clr = '0;
    for (int unsigned n = 0; n < NCH; n++) begin
      if (is_ch && (32'(ch_sel) == n)) begin
        ld_we[n]   = wr_en & (reg_sel == 2'd0);
        ctrl_we[n] = wr_en & (reg_sel == 2'd2);
        eoi_clr[n] = rd_en & (reg_sel == 2'd3);
      end
    end
    if (rd_en && is_glb && (reg_sel == 2'd1)) begin
      eoi_clr = '1;
    end
  end

  // Read mux; registers narrower than 32 bits are zero-extended.
  always_comb begin
    rdata = '0;
    if (is_ch) begin
      for (int unsigned n = 0; n < NCH; n++) begin
        if (32'(ch_sel) == n) begin
          unique case (reg_sel)
            2'd0: rdata = 32'(load_q[n]);
            2'd1: rdata = 32'(cnt_q[n]);
            2'd2: rdata = {29'b0, mask_q[n], mode_q[n], en_q[n]};
            2'd3: rdata = {31'b0, raw_q[n]};
            default: rdata = '0;
          endcase
        end
      end
    end else if (is_glb) begin
      unique case (reg_sel)
        2'd0: rdata = 32'(intr);
        2'd1: rdata = 32'(raw_q);
        2'd2: rdata = 32'(raw_q);
        2'd3: rdata = 32'(psc_q);
        default: rdata = '0;
      endcase
    end
  end

  // Prescaler only runs while some channel is enabled. >= guards against PSC being
  // lowered below the current count.
  always_comb begin
    tick   = (|en_q) && (pcnt_q >= psc_q);
    pcnt_d = pcnt_q + PSC_W'(1);
    if (!(|en_q) || tick) begin
      pcnt_d = '0;
    end
  end

  // EN next value: ETB disable beats ETB enable beats the APB write.
  always_comb begin
    en_d = en_q;
    for (int unsigned n = 0; n < NCH; n++) begin
      if (ctrl_we[n]) begin
        en_d[n] = pwdata[0];
      end
`ifdef TIMER_ETB_EN
      if (etb_trig_en_on[n]) begin
        en_d[n] = 1'b1;
      end
      if (etb_trig_en_off[n]) begin
        en_d[n] = 1'b0;
      end
`endif
    end
  end

  // Channel FSM: next state
  always_comb begin
    for (int unsigned n = 0; n < NCH; n++) begin
      state_d[n] = state_q[n];
      unique case (state_q[n])
        StIdle:  if (en_q[n])  state_d[n] = StRun;
        StRun:   if (!en_q[n]) state_d[n] = StIdle;
        default: state_d[n] = StIdle;
      endcase
    end
  end

  // Channel FSM: counter and expiry outputs. The load cycle on entering RUN never expires.
  always_comb begin
    for (int unsigned n = 0; n < NCH; n++) begin
      cnt_d[n]  = cnt_q[n];
      expire[n] = 1'b0;
      if (en_q[n]) begin
        if (state_q[n] == StIdle) begin
          cnt_d[n] = load_q[n];
        end else if (tick) begin
          if (cnt_q[n] == '0) begin
            expire[n] = 1'b1;
            cnt_d[n]  = mode_q[n] ? load_q[n] : '1;
          end else begin
            cnt_d[n] = cnt_q[n] - CNT_W'(1);
          end
        end
      end
    end
  end

  // A new expiry wins over a same-cycle EOI clear.
  assign raw_d = expire | (raw_q & ~eoi_clr);
  assign intr  = raw_q & ~mask_q;
  assign prdata = prdata_q;

  // Channel FSM and register state
  always_ff @(posedge pclk) begin
    if (preset) begin
      prdata_q <= '0;
      psc_q    <= '0;
      pcnt_q   <= '0;
      en_q     <= '0;
      mode_q   <= '0;
      mask_q   <= '0;
      raw_q    <= '0;
      for (int unsigned n = 0; n < NCH; n++) begin
        load_q[n]  <= '0;
        cnt_q[n]   <= '0;
        state_q[n] <= StIdle;
      end
    end else begin
      if (rd_en) begin
        prdata_q <= rdata;
      end
      if (wr_en && is_glb && (reg_sel == 2'd3)) begin
        psc_q <= pwdata[PSC_W-1:0];
      end
      pcnt_q <= pcnt_d;
      en_q   <= en_d;
      raw_q  <= raw_d;
      for (int unsigned n = 0; n < NCH; n++) begin
        if (ld_we[n]) begin
          load_q[n] <= pwdata[CNT_W-1:0];
        end
        if (ctrl_we[n]) begin
          mode_q[n] <= pwdata[1];
          mask_q[n] <= pwdata[2];
        end
        cnt_q[n]   <= cnt_d[n];
        state_q[n] <= state_d[n];
      end
    end
  end

`ifdef TIMER_ETB_EN
  logic [NCH-1:0] trig_q;

  always_ff @(posedge pclk) begin
    if (preset) begin
      trig_q <= '0;
    end else begin
      trig_q <= expire;
    end
  end

  assign tim_etb_trig = trig_q;
`else
  logic unused_etb;
  assign unused_etb   = ^{etb_trig_en_on, etb_trig_en_off};
  assign tim_etb_trig = '0;
`endif

endmodule
